// File: rtl/mmu_ptw_arb.sv
// -----------------------------------------------------------------------------
// mmu_ptw_arb
//
// Shares the single page-table-walk read port into the dcache between the
// instruction MMU (immu) and the data MMU (dmmu) walkers. One request is
// granted at a time and exactly one transaction is outstanding downstream.
// The read response is routed back to the walker that owns the transaction.
//
// Optional feature macro: MMU_ARB_ROUND_ROBIN_EN
//   defined   : round-robin between walkers. After each completed transaction
//               the pointer moves to the walker that did not own it, and the
//               pointed walker wins simultaneous requests.
//   undefined : fixed priority. immu always wins, and no pointer is kept.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   immu_ar*/dmmu_ar*          walker read-address channels (valid/ready/user/addr)
//   immu_r*/dmmu_r*            walker read-data channels (valid/ready/resp/data)
//   mmu_ar*                    downstream read-address channel to the dcache
//   mmu_r*                     downstream read-data channel from the dcache
// -----------------------------------------------------------------------------
module mmu_ptw_arb (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        immu_arvalid,
    output logic        immu_arready,
    input  logic        immu_aruser,
    input  logic [63:0] immu_araddr,
    output logic        immu_rvalid,
    input  logic        immu_rready,
    output logic [1:0]  immu_rresp,
    output logic [63:0] immu_rdata,

    input  logic        dmmu_arvalid,
    output logic        dmmu_arready,
    input  logic        dmmu_aruser,
    input  logic [63:0] dmmu_araddr,
    output logic        dmmu_rvalid,
    input  logic        dmmu_rready,
    output logic [1:0]  dmmu_rresp,
    output logic [63:0] dmmu_rdata,

    output logic        mmu_arvalid,
    input  logic        mmu_arready,
    output logic        mmu_aruser,
    output logic [63:0] mmu_araddr,
    input  logic        mmu_rvalid,
    output logic        mmu_rready,
    input  logic [1:0]  mmu_rresp,
    input  logic [63:0] mmu_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;     // 0 = immu, 1 = dmmu
    logic [63:0] araddr_q, araddr_d;
    logic        aruser_q, aruser_d;
    logic        grant_dmmu;

`ifdef MMU_ARB_ROUND_ROBIN_EN
    logic        ptr_q, ptr_d;         // 0 = immu favoured, 1 = dmmu favoured

    always_comb begin
        // The pointer only matters when both walkers request together.
        if (immu_arvalid && dmmu_arvalid) begin
            grant_dmmu = ptr_q;
        end else begin
            grant_dmmu = dmmu_arvalid;
        end
    end
`else
    always_comb begin
        grant_dmmu = dmmu_arvalid && !immu_arvalid;
    end
`endif

    assign mmu_arvalid = (state_q == ST_ADDR);
    assign mmu_araddr  = araddr_q;
    assign mmu_aruser  = aruser_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        araddr_d     = araddr_q;
        aruser_d     = aruser_q;
`ifdef MMU_ARB_ROUND_ROBIN_EN
        ptr_d        = ptr_q;
`endif
        immu_arready = 1'b0;
        dmmu_arready = 1'b0;
        mmu_rready   = 1'b0;
        immu_rvalid  = 1'b0;
        immu_rresp   = '0;
        immu_rdata   = '0;
        dmmu_rvalid  = 1'b0;
        dmmu_rresp   = '0;
        dmmu_rdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (immu_arvalid || dmmu_arvalid) begin
                    immu_arready = !grant_dmmu;
                    dmmu_arready = grant_dmmu;
                    owner_d      = grant_dmmu;
                    araddr_d     = grant_dmmu ? dmmu_araddr : immu_araddr;
                    aruser_d     = grant_dmmu ? dmmu_aruser : immu_aruser;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (mmu_arready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Response path is purely combinational through the owner mux.
                if (owner_q) begin
                    mmu_rready  = dmmu_rready;
                    dmmu_rvalid = mmu_rvalid;
                    dmmu_rresp  = mmu_rresp;
                    dmmu_rdata  = mmu_rdata;
                end else begin
                    mmu_rready  = immu_rready;
                    immu_rvalid = mmu_rvalid;
                    immu_rresp  = mmu_rresp;
                    immu_rdata  = mmu_rdata;
                end
                if (mmu_rvalid && mmu_rready) begin
                    state_d = ST_IDLE;
`ifdef MMU_ARB_ROUND_ROBIN_EN
                    ptr_d   = !owner_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            araddr_q <= '0;
            aruser_q <= 1'b0;
`ifdef MMU_ARB_ROUND_ROBIN_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            araddr_q <= araddr_d;
            aruser_q <= aruser_d;
`ifdef MMU_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmu_ptw_arb.sv
// -----------------------------------------------------------------------------
// tb_mmu_ptw_arb
//
// Self-checking bench for mmu_ptw_arb. Directed scenarios follow the block's
// behaviour, then randomized traffic is checked against a transaction-level
// model: a winner function plus a favoured-walker variable.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_mmu_ptw_arb;

    logic        clk;
    logic        rst_n;
    logic        immu_arvalid, immu_arready, immu_aruser, immu_rvalid, immu_rready;
    logic [63:0] immu_araddr, immu_rdata;
    logic [1:0]  immu_rresp;
    logic        dmmu_arvalid, dmmu_arready, dmmu_aruser, dmmu_rvalid, dmmu_rready;
    logic [63:0] dmmu_araddr, dmmu_rdata;
    logic [1:0]  dmmu_rresp;
    logic        mmu_arvalid, mmu_arready, mmu_aruser, mmu_rvalid, mmu_rready;
    logic [63:0] mmu_araddr, mmu_rdata;
    logic [1:0]  mmu_rresp;

    int n_checks = 0;
    int n_fail   = 0;
    logic ref_ptr = 1'b0;    // model: walker favoured on a tie (0 immu, 1 dmmu)

    mmu_ptw_arb dut (
        .clk(clk), .rst_n(rst_n),
        .immu_arvalid(immu_arvalid), .immu_arready(immu_arready),
        .immu_aruser(immu_aruser), .immu_araddr(immu_araddr),
        .immu_rvalid(immu_rvalid), .immu_rready(immu_rready),
        .immu_rresp(immu_rresp), .immu_rdata(immu_rdata),
        .dmmu_arvalid(dmmu_arvalid), .dmmu_arready(dmmu_arready),
        .dmmu_aruser(dmmu_aruser), .dmmu_araddr(dmmu_araddr),
        .dmmu_rvalid(dmmu_rvalid), .dmmu_rready(dmmu_rready),
        .dmmu_rresp(dmmu_rresp), .dmmu_rdata(dmmu_rdata),
        .mmu_arvalid(mmu_arvalid), .mmu_arready(mmu_arready),
        .mmu_aruser(mmu_aruser), .mmu_araddr(mmu_araddr),
        .mmu_rvalid(mmu_rvalid), .mmu_rready(mmu_rready),
        .mmu_rresp(mmu_rresp), .mmu_rdata(mmu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Model winner: 0 = immu, 1 = dmmu.
    function automatic logic ref_winner(input logic ri, input logic rd);
`ifdef MMU_ARB_ROUND_ROBIN_EN
        if (ri && rd) return ref_ptr;
        return rd;
`else
        return rd && !ri;
`endif
    endfunction

    function automatic logic ref_ptr_after(input logic winner);
`ifdef MMU_ARB_ROUND_ROBIN_EN
        return !winner;
`else
        return ref_ptr;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        immu_arvalid = 0; immu_aruser = 0; immu_araddr = '0; immu_rready = 0;
        dmmu_arvalid = 0; dmmu_aruser = 0; dmmu_araddr = '0; dmmu_rready = 0;
        mmu_arready = 0; mmu_rvalid = 0; mmu_rresp = '0; mmu_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        ref_ptr = 0;
        #1;
        n_checks++; if (mmu_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got=%b exp=0", mmu_arvalid); end
        n_checks++; if (mmu_araddr !== 64'h0) begin n_fail++; $display("FAIL reset_araddr got=%h exp=0", mmu_araddr); end
        n_checks++; if (mmu_aruser !== 1'b0) begin n_fail++; $display("FAIL reset_aruser got=%b exp=0", mmu_aruser); end
        n_checks++; if (mmu_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got=%b exp=0", mmu_rready); end
        n_checks++; if ({immu_rvalid, dmmu_rvalid, immu_arready, dmmu_arready} !== 4'b0) begin
            n_fail++; $display("FAIL reset_walker_outs got=%b exp=0000", {immu_rvalid, dmmu_rvalid, immu_arready, dmmu_arready}); end
    endtask

    task automatic test_single_immu();
        immu_arvalid = 1; immu_araddr = 64'h8000_1000; immu_aruser = 1;
        #1;
        n_checks++; if (immu_arready !== 1'b1) begin n_fail++; $display("FAIL single_immu_arready got=%b exp=1", immu_arready); end
        n_checks++; if (dmmu_arready !== 1'b0) begin n_fail++; $display("FAIL single_dmmu_arready got=%b exp=0", dmmu_arready); end
        tick();
        immu_arvalid = 0; mmu_arready = 1;
        #1;
        n_checks++; if (immu_arready !== 1'b0) begin n_fail++; $display("FAIL single_arready_pulse got=%b exp=0", immu_arready); end
        n_checks++; if (mmu_arvalid !== 1'b1) begin n_fail++; $display("FAIL single_mmu_arvalid got=%b exp=1", mmu_arvalid); end
        n_checks++; if (mmu_araddr !== 64'h8000_1000) begin n_fail++; $display("FAIL single_araddr got=%h exp=80001000", mmu_araddr); end
        n_checks++; if (mmu_aruser !== 1'b1) begin n_fail++; $display("FAIL single_aruser got=%b exp=1", mmu_aruser); end
        tick();
        mmu_arready = 0; immu_rready = 1;
        #1;
        n_checks++; if (immu_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid_early got=%b exp=0", immu_rvalid); end
        tick();
        mmu_rvalid = 1; mmu_rdata = 64'h2000_0001; mmu_rresp = 2'd0;
        #1;
        n_checks++; if (immu_rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid got=%b exp=1", immu_rvalid); end
        n_checks++; if (immu_rdata !== 64'h2000_0001) begin n_fail++; $display("FAIL single_rdata got=%h exp=20000001", immu_rdata); end
        n_checks++; if (dmmu_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_dmmu_rvalid got=%b exp=0", dmmu_rvalid); end
        n_checks++; if (mmu_rready !== 1'b1) begin n_fail++; $display("FAIL single_mmu_rready got=%b exp=1", mmu_rready); end
        tick();
        mmu_rvalid = 0; immu_rready = 0;
        #1;
        n_checks++; if (mmu_arvalid !== 1'b0) begin n_fail++; $display("FAIL single_back_idle got=%b exp=0", mmu_arvalid); end
        ref_ptr = ref_ptr_after(1'b0);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq;
`ifdef MMU_ARB_ROUND_ROBIN_EN
        exp_seq = 4'b1010;   // bit k: grant k goes to dmmu
`else
        exp_seq = 4'b0000;
`endif
        clear_inputs();
        rst_n = 0; tick(); rst_n = 1; ref_ptr = 0;
        immu_arvalid = 1; immu_araddr = 64'h1111_0000; immu_aruser = 0;
        dmmu_arvalid = 1; dmmu_araddr = 64'h2222_0000; dmmu_aruser = 1;
        immu_rready = 1; dmmu_rready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if ({dmmu_arready, immu_arready} !== {exp_seq[k], !exp_seq[k]}) begin
                n_fail++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {dmmu_arready, immu_arready}, {exp_seq[k], !exp_seq[k]}); end
            tick();
            mmu_arready = 1;
            #1;
            n_checks++; if (mmu_araddr !== (exp_seq[k] ? 64'h2222_0000 : 64'h1111_0000)) begin
                n_fail++; $display("FAIL rr_araddr%0d got=%h", k, mmu_araddr); end
            tick();
            mmu_arready = 0; mmu_rvalid = 1;
            tick();
            mmu_rvalid = 0;
            ref_ptr = ref_ptr_after(exp_seq[k]);
        end
        immu_arvalid = 0; dmmu_arvalid = 0; immu_rready = 0; dmmu_rready = 0;
        tick();
    endtask

    task automatic test_addr_stall();
        immu_arvalid = 1; immu_araddr = 64'h0000_0000_CAFE_0008; immu_aruser = 0;
        tick();
        immu_arvalid = 0;
        dmmu_arvalid = 1; dmmu_araddr = 64'h0000_0000_BEEF_0010;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (mmu_arvalid !== 1'b1 || mmu_araddr !== 64'hCAFE_0008) begin
                n_fail++; $display("FAIL stall_hold%0d got=%b/%h exp=1/cafe0008", c, mmu_arvalid, mmu_araddr); end
            n_checks++; if ({immu_arready, dmmu_arready} !== 2'b00) begin
                n_fail++; $display("FAIL stall_arready%0d got=%b exp=00", c, {immu_arready, dmmu_arready}); end
            tick();
        end
        mmu_arready = 1;
        tick();
        mmu_arready = 0; mmu_rvalid = 1; immu_rready = 1;
        #1;
        n_checks++; if (dmmu_arready !== 1'b0 || immu_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL stall_resp got=%b%b exp=01", dmmu_arready, immu_rvalid); end
        tick();
        mmu_rvalid = 0; immu_rready = 0;
        ref_ptr = ref_ptr_after(1'b0);
        #1;
        n_checks++; if (dmmu_arready !== 1'b1) begin n_fail++; $display("FAIL stall_pending_grant got=%b exp=1", dmmu_arready); end
        dmmu_arvalid = 0;    // withdraw before the edge; no grant taken
        tick();
    endtask

    task automatic test_dmmu_backpressure();
        dmmu_arvalid = 1; dmmu_araddr = 64'h0000_0040_0000_1238; dmmu_aruser = 1;
        tick();
        dmmu_arvalid = 0; mmu_arready = 1;
        #1;
        n_checks++; if (mmu_araddr !== 64'h0000_0040_0000_1238 || mmu_aruser !== 1'b1) begin
            n_fail++; $display("FAIL bp_addr got=%h/%b", mmu_araddr, mmu_aruser); end
        tick();
        mmu_arready = 0;
        mmu_rvalid = 1; mmu_rdata = 64'hDEAD_BEEF_0123_4567; mmu_rresp = 2'd1;
        dmmu_rready = 0; immu_rready = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (mmu_rready !== 1'b0) begin n_fail++; $display("FAIL bp_rready%0d got=%b exp=0", c, mmu_rready); end
            n_checks++; if (dmmu_rvalid !== 1'b1 || immu_rvalid !== 1'b0 || immu_rdata !== 64'h0) begin
                n_fail++; $display("FAIL bp_route%0d got=%b%b/%h", c, dmmu_rvalid, immu_rvalid, immu_rdata); end
            n_checks++; if (dmmu_rdata !== 64'hDEAD_BEEF_0123_4567 || dmmu_rresp !== 2'd1) begin
                n_fail++; $display("FAIL bp_data%0d got=%h/%0d", c, dmmu_rdata, dmmu_rresp); end
            tick();
        end
        dmmu_rready = 1;
        #1;
        n_checks++; if (mmu_rready !== 1'b1) begin n_fail++; $display("FAIL bp_rready_release got=%b exp=1", mmu_rready); end
        tick();
        mmu_rvalid = 0; dmmu_rready = 0; immu_rready = 0;
        ref_ptr = ref_ptr_after(1'b1);
        mmu_rvalid = 1;
        #1;
        n_checks++; if (dmmu_rvalid !== 1'b0 || mmu_rready !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle got=%b%b exp=00", dmmu_rvalid, mmu_rready); end
        mmu_rvalid = 0;
    endtask

    task automatic test_error_resp();
        immu_arvalid = 1; immu_araddr = 64'h0000_0000_8000_2000;
        tick();
        immu_arvalid = 0; mmu_arready = 1;
        tick();
        mmu_arready = 0; mmu_rvalid = 1; mmu_rresp = 2'd2; mmu_rdata = 64'h5; immu_rready = 1;
        #1;
        n_checks++; if (immu_rresp !== 2'd2 || immu_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL err_rresp got=%0d/%b exp=2/1", immu_rresp, immu_rvalid); end
        tick();
        mmu_rvalid = 0; mmu_rresp = 2'd0; immu_rready = 0;
        ref_ptr = ref_ptr_after(1'b0);
        dmmu_arvalid = 1; dmmu_araddr = 64'h0000_0000_9000_3000; dmmu_aruser = 0;
        #1;
        n_checks++; if (dmmu_arready !== 1'b1) begin n_fail++; $display("FAIL err_next_grant got=%b exp=1", dmmu_arready); end
        tick();
        dmmu_arvalid = 0; mmu_arready = 1;
        #1;
        n_checks++; if (mmu_araddr !== 64'h9000_3000) begin n_fail++; $display("FAIL err_next_addr got=%h exp=90003000", mmu_araddr); end
        tick();
        mmu_arready = 0; mmu_rvalid = 1; dmmu_rready = 1;
        tick();
        mmu_rvalid = 0; dmmu_rready = 0;
        ref_ptr = ref_ptr_after(1'b1);
    endtask

    task automatic test_reset_mid_resp();
        immu_arvalid = 1; immu_araddr = 64'h0000_0000_7777_0000; immu_aruser = 1;
        tick();
        immu_arvalid = 0; mmu_arready = 1;
        tick();
        mmu_arready = 0;
        rst_n = 0;
        tick();
        rst_n = 1; ref_ptr = 0;
        mmu_rvalid = 1; immu_rready = 1;
        #1;
        n_checks++; if ({mmu_arvalid, mmu_aruser, mmu_rready, immu_rvalid, dmmu_rvalid} !== 5'b0 || mmu_araddr !== 64'h0) begin
            n_fail++; $display("FAIL rst_mid_outs got=%b/%h exp=00000/0", {mmu_arvalid, mmu_aruser, mmu_rready, immu_rvalid, dmmu_rvalid}, mmu_araddr); end
        mmu_rvalid = 0; immu_rready = 0;
        immu_arvalid = 1; immu_araddr = 64'h0000_0000_7777_0100; immu_aruser = 0;
        #1;
        n_checks++; if (immu_arready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_regrant got=%b exp=1", immu_arready); end
        tick();
        immu_arvalid = 0; mmu_arready = 1;
        #1;
        n_checks++; if (mmu_araddr !== 64'h7777_0100) begin n_fail++; $display("FAIL rst_mid_addr got=%h exp=77770100", mmu_araddr); end
        tick();
        mmu_arready = 0; mmu_rvalid = 1; immu_rready = 1;
        tick();
        mmu_rvalid = 0; immu_rready = 0;
        ref_ptr = ref_ptr_after(1'b0);
    endtask

    task automatic test_random_traffic();
        logic        pi, pd, ui, ud, w, orr, done;
        logic [63:0] ai, ad, ea;
        int unsigned stall, rdel, odel;
        pi = 0; pd = 0; ui = 0; ud = 0; ai = '0; ad = '0;
        for (int t = 0; t < 40; t++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; ai = {$urandom, $urandom}; ui = 1'($urandom); end
            if (!pd && $urandom_range(0, 1) == 1) begin pd = 1; ad = {$urandom, $urandom}; ud = 1'($urandom); end
            if (!pi && !pd) begin
                if ($urandom_range(0, 1) == 1) begin pd = 1; ad = {$urandom, $urandom}; ud = 1'($urandom); end
                else begin pi = 1; ai = {$urandom, $urandom}; ui = 1'($urandom); end
            end
            immu_arvalid = pi; immu_araddr = ai; immu_aruser = ui;
            dmmu_arvalid = pd; dmmu_araddr = ad; dmmu_aruser = ud;
            w = ref_winner(pi, pd);
            ea = w ? ad : ai;
            #1;
            n_checks++; if ({dmmu_arready, immu_arready} !== {w, !w}) begin
                n_fail++; $display("FAIL rnd_grant t%0d got=%b exp=%b", t, {dmmu_arready, immu_arready}, {w, !w}); end
            tick();
            if (w) begin pd = 0; dmmu_arvalid = 0; end else begin pi = 0; immu_arvalid = 0; end
            stall = $urandom_range(0, 3);
            for (int unsigned c = 0; c <= stall; c++) begin
                mmu_arready = (c == stall);
                #1;
                n_checks++; if (mmu_arvalid !== 1'b1 || mmu_araddr !== ea || mmu_aruser !== (w ? ud : ui)) begin
                    n_fail++; $display("FAIL rnd_addr t%0d got=%b/%h exp=1/%h", t, mmu_arvalid, mmu_araddr, ea); end
                n_checks++; if ({immu_arready, dmmu_arready} !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_busy_arready t%0d got=%b exp=00", t, {immu_arready, dmmu_arready}); end
                tick();
            end
            mmu_arready = 0;
            rdel = $urandom_range(0, 2);
            odel = $urandom_range(0, 2);
            done = 0;
            for (int unsigned c = 0; c < 8 && !done; c++) begin
                mmu_rvalid = (c >= rdel);
                orr = (c >= odel);
                mmu_rdata = {$urandom, $urandom};
                mmu_rresp = 2'($urandom);
                if (w) begin dmmu_rready = orr; immu_rready = 1'($urandom); end
                else   begin immu_rready = orr; dmmu_rready = 1'($urandom); end
                #1;
                n_checks++; if (mmu_rready !== orr) begin
                    n_fail++; $display("FAIL rnd_mmu_rready t%0d got=%b exp=%b", t, mmu_rready, orr); end
                if (w) begin
                    n_checks++; if (dmmu_rvalid !== mmu_rvalid || dmmu_rdata !== mmu_rdata || dmmu_rresp !== mmu_rresp) begin
                        n_fail++; $display("FAIL rnd_owner_resp t%0d got=%b/%h/%0d", t, dmmu_rvalid, dmmu_rdata, dmmu_rresp); end
                    n_checks++; if (immu_rvalid !== 1'b0 || immu_rdata !== 64'h0 || immu_rresp !== 2'd0) begin
                        n_fail++; $display("FAIL rnd_other_resp t%0d got=%b/%h/%0d exp=0", t, immu_rvalid, immu_rdata, immu_rresp); end
                end else begin
                    n_checks++; if (immu_rvalid !== mmu_rvalid || immu_rdata !== mmu_rdata || immu_rresp !== mmu_rresp) begin
                        n_fail++; $display("FAIL rnd_owner_resp t%0d got=%b/%h/%0d", t, immu_rvalid, immu_rdata, immu_rresp); end
                    n_checks++; if (dmmu_rvalid !== 1'b0 || dmmu_rdata !== 64'h0 || dmmu_rresp !== 2'd0) begin
                        n_fail++; $display("FAIL rnd_other_resp t%0d got=%b/%h/%0d exp=0", t, dmmu_rvalid, dmmu_rdata, dmmu_rresp); end
                end
                done = mmu_rvalid && orr;
                tick();
            end
            n_checks++; if (!done) begin n_fail++; $display("FAIL rnd_resp_bound t%0d got=incomplete exp=handshake", t); end
            mmu_rvalid = 0; immu_rready = 0; dmmu_rready = 0;
            ref_ptr = ref_ptr_after(w);
        end
        immu_arvalid = 0; dmmu_arvalid = 0;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_single_immu();
        test_round_robin();
        test_addr_stall();
        test_dmmu_backpressure();
        test_error_resp();
        test_reset_mid_resp();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
